// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and elaboration-time KMP table builder for the serial pattern detector.
package seq_det_pkg;
  localparam int MAX_PAT_LEN = 16;
  typedef logic [4:0] st_t;
  typedef struct packed {
    st_t [MAX_PAT_LEN-1:0][1:0] nxt;
    logic [3:0]                 fail;
  } kmp_t;
  function automatic int state_w(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction
  // Bit i of the pattern in arrival order; the MSB of the used field arrives first.
  function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pattern, input int pat_len, input int i);
    return pattern[4'(pat_len - 1 - i)];
  endfunction
  function automatic kmp_t build_kmp(input logic [MAX_PAT_LEN-1:0] pattern, input int pat_len);
    kmp_t t;
    logic ok;
    logic s;
    t = '0;
    for (int k = 0; k < pat_len; k++)
      for (int b = 0; b < 2; b++)
        for (int l = 1; l <= k + 1; l++) begin
          ok = 1'b1;
          for (int j = 0; j < l; j++) begin
            s = (k + 1 - l + j == k) ? b[0] : pat_bit(pattern, pat_len, k + 1 - l + j);
            if (pat_bit(pattern, pat_len, j) != s) ok = 1'b0;
          end
          if (ok) t.nxt[4'(k)][1'(b)] = st_t'(l);
        end
    for (int l = 1; l < pat_len; l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++)
        if (pat_bit(pattern, pat_len, j) != pat_bit(pattern, pat_len, pat_len - l + j)) ok = 1'b0;
      if (ok) t.fail = 4'(l);
    end
    return t;
  endfunction
endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial stream and flag bundle; counter signals exist only with SEQ_DET_COUNT_EN.
interface seq_detector_param_if #(parameter int CNT_W = 8);
  logic x;
  logic en;
  logic overlap;
  logic y;
  logic y1;
`ifdef SEQ_DET_COUNT_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] match_cnt;
  modport master (output x, en, overlap, cnt_clr, input y, y1, match_cnt);
  modport slave  (input x, en, overlap, cnt_clr, output y, y1, match_cnt);
`else
  localparam int unused_cnt_w = CNT_W;
  modport master (output x, en, overlap, input y, y1);
  modport slave  (input x, en, overlap, output y, y1);
`endif
endinterface

// File: rtl/seq_det_match_cnt.sv
// seq_det_match_cnt: saturating match counter with synchronous clear.
module seq_det_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: KMP serial pattern detector with Moore (y) and Mealy (y1) flags.
// Optional saturating match counter under SEQ_DET_COUNT_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter logic [MAX_PAT_LEN-1:0] PATTERN = 16'b1011,
  parameter int                     PAT_LEN = 4,
  parameter int                     CNT_W   = 8
) (
  input logic                 clk,
  input logic                 rst,
  seq_detector_param_if.slave bus
);
  localparam int             SW       = state_w(PAT_LEN);
  localparam kmp_t           KMP      = build_kmp(PATTERN, PAT_LEN);
  localparam logic [SW-1:0]  MATCH_ST = SW'(PAT_LEN);
  if (PAT_LEN < 2 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_len
    $error("seq_detector_param: PAT_LEN must be in 2..16");
  end
  logic [SW-1:0] k_q, k_d;
  logic [3:0]    from;
  st_t           tgt;
  logic          hit;
  // Leaving MATCH restarts from the border (overlap) or from empty before consuming x.
  always_comb begin
    from = (k_q == MATCH_ST) ? (bus.overlap ? KMP.fail : 4'd0) : 4'(k_q);
    tgt  = KMP.nxt[from][bus.x];
    hit  = bus.en && tgt == st_t'(PAT_LEN);
    k_d  = bus.en ? SW'(tgt) : k_q;
  end
  always_ff @(posedge clk)
    if (!rst) k_q <= '0;
    else k_q <= k_d;
  assign bus.y  = k_q == MATCH_ST;
  assign bus.y1 = rst && hit;
`ifdef SEQ_DET_COUNT_EN
  seq_det_match_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (bus.cnt_clr),
    .cnt (bus.match_cnt)
  );
`else
  localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed checks of the 1011 detector; counter checks only with SEQ_DET_COUNT_EN.
module tb_seq_detector_param;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total = 0;
  seq_detector_param_if #(.CNT_W(CW)) bus ();
  seq_detector_param #(.PATTERN(16'b1011), .PAT_LEN(4), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  always #5 clk = ~clk;

  task automatic drive(input logic xv, input logic ev);
    @(negedge clk);
    bus.x  = xv;
    bus.en = ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.x = 1'b0;
    bus.en = 1'b0;
`ifdef SEQ_DET_COUNT_EN
    bus.cnt_clr = 1'b0;
`endif
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] bits = 4'b1011;
    logic [3:0] ey1  = 4'b0001;
    bus.overlap = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1);
      total++;
      if (bus.y1 !== 1'b0) $display("FAIL reset_y1 edge %0d: got %b want 0", i, bus.y1);
      else pass_cnt++;
      tick();
      total++;
      if (bus.y !== 1'b0) $display("FAIL reset_y edge %0d: got %b want 0", i, bus.y);
      else pass_cnt++;
`ifdef SEQ_DET_COUNT_EN
      total++;
      if (bus.match_cnt !== '0) $display("FAIL reset_cnt edge %0d: got %0d want 0", i, bus.match_cnt);
      else pass_cnt++;
`endif
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(bits[3-i], 1'b1);
      total++;
      if (bus.y1 !== ey1[3-i]) $display("FAIL post_reset_y1 bit %0d: got %b want %b", i, bus.y1, ey1[3-i]);
      else pass_cnt++;
      tick();
      total++;
      if (bus.y !== ey1[3-i]) $display("FAIL post_reset_y bit %0d: got %b want %b", i, bus.y, ey1[3-i]);
      else pass_cnt++;
    end
  endtask

  task automatic run_stream(input logic ov, input logic [6:0] ey1, input int ecnt, input string nm);
    logic [6:0] bits = 7'b1011011;
    apply_reset();
    bus.overlap = ov;
    for (int i = 0; i < 7; i++) begin
      drive(bits[6-i], 1'b1);
      total++;
      if (bus.y1 !== ey1[6-i]) $display("FAIL %s_y1 bit %0d: got %b want %b", nm, i, bus.y1, ey1[6-i]);
      else pass_cnt++;
      tick();
      total++;
      if (bus.y !== ey1[6-i]) $display("FAIL %s_y bit %0d: got %b want %b", nm, i, bus.y, ey1[6-i]);
      else pass_cnt++;
    end
`ifdef SEQ_DET_COUNT_EN
    total++;
    if (int'(bus.match_cnt) != ecnt) $display("FAIL %s_cnt: got %0d want %0d", nm, bus.match_cnt, ecnt);
    else pass_cnt++;
`else
    if (ecnt < 0) $display("bad count argument for %s", nm);
`endif
  endtask

  task automatic test_overlap();
    run_stream(1'b1, 7'b0001001, 2, "overlap");
  endtask

  task automatic test_non_overlap();
    run_stream(1'b0, 7'b0001000, 1, "non_overlap");
  endtask

  task automatic test_enable_gaps();
    logic [9:0] xs  = 10'b1011011010;
    logic [9:0] ens = 10'b1110001001;
    logic [9:0] ey1 = 10'b0000001000;
    logic [9:0] ey  = 10'b0000001110;
    apply_reset();
    bus.overlap = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(xs[9-i], ens[9-i]);
      total++;
      if (bus.y1 !== ey1[9-i]) $display("FAIL gap_y1 step %0d: got %b want %b", i, bus.y1, ey1[9-i]);
      else pass_cnt++;
      tick();
      total++;
      if (bus.y !== ey[9-i]) $display("FAIL gap_y step %0d: got %b want %b", i, bus.y, ey[9-i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] pre  = 3'b101;
    logic [6:0] post = 7'b0111011;
    logic [6:0] ey1  = 7'b0000001;
    apply_reset();
    bus.overlap = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(pre[2-i], 1'b1);
      tick();
    end
    @(negedge clk);
    rst = 1'b0;
    bus.x = 1'b1;
    bus.en = 1'b1;
    #1;
    total++;
    if (bus.y1 !== 1'b0) $display("FAIL midrst_y1_forced: got %b want 0", bus.y1);
    else pass_cnt++;
    tick();
    rst = 1'b1;
    total++;
    if (bus.y !== 1'b0) $display("FAIL midrst_y: got %b want 0", bus.y);
    else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      drive(post[6-i], 1'b1);
      total++;
      if (bus.y1 !== ey1[6-i]) $display("FAIL midrst_post_y1 bit %0d: got %b want %b", i, bus.y1, ey1[6-i]);
      else pass_cnt++;
      tick();
      total++;
      if (bus.y !== ey1[6-i]) $display("FAIL midrst_post_y bit %0d: got %b want %b", i, bus.y, ey1[6-i]);
      else pass_cnt++;
    end
  endtask

`ifdef SEQ_DET_COUNT_EN
  task automatic test_counter();
    logic [18:0] bits = 19'b1011011011011011011;
    logic [18:0] ey1  = 19'b0001001001001001001;
    int m = 0;
    int ecnt;
    apply_reset();
    bus.overlap = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(bits[18-i], 1'b1);
      bus.cnt_clr = (i == 18);
      #1;
      total++;
      if (bus.y1 !== ey1[18-i]) $display("FAIL cnt_y1 bit %0d: got %b want %b", i, bus.y1, ey1[18-i]);
      else pass_cnt++;
      tick();
      if (ey1[18-i]) m++;
      ecnt = (i == 18) ? 0 : (m > 3 ? 3 : m);
      total++;
      if (int'(bus.match_cnt) != ecnt) $display("FAIL cnt_value bit %0d: got %0d want %0d", i, bus.match_cnt, ecnt);
      else pass_cnt++;
      total++;
      if (bus.y !== ey1[18-i]) $display("FAIL cnt_y bit %0d: got %b want %b", i, bus.y, ey1[18-i]);
      else pass_cnt++;
    end
    bus.cnt_clr = 1'b0;
  endtask
`endif

  initial begin
    bus.x = 1'b0;
    bus.en = 1'b0;
    bus.overlap = 1'b1;
`ifdef SEQ_DET_COUNT_EN
    bus.cnt_clr = 1'b0;
`endif
    test_reset();
    test_overlap();
    test_non_overlap();
    test_enable_gaps();
    test_mid_reset();
`ifdef SEQ_DET_COUNT_EN
    test_counter();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, successor to the fixed-pattern Moore/Mealy detectors in the FSM set. It watches a 1-bit serial stream qualified by an enable. It flags every occurrence of a compile-time pattern of up to 16 bits, with both a registered (Moore) flag and a same-cycle (Mealy) flag. Overlapping vs. non-overlapping detection is selectable at run time, and an optional saturating match counter is available.

## Interface
- PATTERN, 4'b1011, pattern bits; MSB is the first bit received
- PAT_LEN, 4, pattern length in bits, legal range 2..16
- CNT_W, 8, match counter width (used only with counter compiled in)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk
- x  input  1  serial data bit
- en  input  1  x is consumed on a rising edge only when en=1
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- y  output  1  Moore flag, registered
- y1  output  1  Mealy flag, combinational
- match_cnt  output  CNT_W  saturating match count (only with SEQ_DET_COUNT_EN)
- cnt_clr  input  1  synchronous counter clear (only with SEQ_DET_COUNT_EN)

## Operation
- State k in 0..PAT_LEN is the number of leading pattern bits currently matched. Encoding is binary, $clog2(PAT_LEN+1) bits.
- Transition on en=1: next k is the length of the longest pattern prefix that is a suffix of (matched prefix of length k, then x). This is KMP-style; it is not a plain reset to 0 on a mismatch.
- k = PAT_LEN is the MATCH state.
- Leaving MATCH:
  - overlap=1: continue from the KMP failure length F(PAT_LEN).
  - overlap=0: continue from state 0 before applying x.
- en=0: state, y and counter hold; y1=0.
- y = 1 exactly while the state is MATCH.
- y1 = en & (the transition taken this cycle lands in MATCH).
- overlap may change on any cycle. It only affects the transition out of MATCH on that cycle.
- Reset (rst=0 at an edge): state goes to 0, y=0, match_cnt=0. rst overrides en and cnt_clr. A reset mid-pattern discards the partial match.
- y1 is forced to 0 while rst=0.

## Timing
- A bit is accepted on the rising edge where en=1.
- y1 rises combinationally in the cycle the final pattern bit is presented (before the edge).
- y rises one cycle later, after that edge, and stays high for exactly one accepted bit. If en=0 follows, y stays high until the next accepted bit.
- Back-to-back matches in overlap mode give y high on consecutive accepted bits only when the pattern allows it (for example, all-ones patterns).
- match_cnt increments on the same edge at which the state enters MATCH, so it is visible with y.
- match_cnt saturates at 2^CNT_W-1.
- cnt_clr and a match on the same edge: the count ends at 0 (clear wins).

## Configuration
- Macro: SEQ_DET_COUNT_EN.
- Defined: match_cnt and cnt_clr ports exist with the behaviour above.
- Undefined: neither port exists, there is no counter logic, and y/y1 behaviour is identical.

## Structure
- Shared package seq_det_pkg contains:
  - the MAX_PAT_LEN=16 constant;
  - the state width function;
  - the elaboration-time function that builds the next-state table (for each k, x) and F(PAT_LEN) from PATTERN/PAT_LEN.
- The top module holds the state register, output decode and overlap handling.
- One sub-module, seq_det_match_cnt, holds the saturating counter with clear. It is instantiated only under SEQ_DET_COUNT_EN.
- An elaboration check rejects PAT_LEN outside 2..16.

## Test plan
- Reset: hold rst=0 for 2 edges with x=1, en=1. Require y=0, y1=0, match_cnt=0 throughout. After release, the first accepted bit starts from state 0.
- Overlap, PATTERN=1011: feed 1,0,1,1,0,1,1 with overlap=1, en=1. Require y1 high on bits 4 and 7, y high the cycle after each, match_cnt=2.
- Non-overlap: same stream with overlap=0. Require a match only on bit 4 and match_cnt=1.
- Enable gaps: feed 1,0,1 then en=0 for 3 cycles (x toggling), then 1. Require no y1 during the gap, y1 on the final bit, y the next cycle and held while en=0 after it.
- Mid-pattern reset: feed 1,0,1, then rst=0 for one edge, then 1. Require no match. Then 0,1,1 completes no match; a full 1,0,1,1 afterwards matches.
- Counter (CNT_W=2): produce 5 matches and require match_cnt to saturate at 3. Then assert cnt_clr on the same edge as a new match and require match_cnt=0 with y=1.
